// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported unified memory between fetch (read-only) and data (load/store) requests.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
`ifdef ARB_PERF_CNT_EN
  parameter int unsigned CNT_W = 16,
`endif
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_conflict,
  output logic [CNT_W-1:0] perf_busy
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t                state, state_nxt;
  logic [STARVE_W-1:0]   starve_cnt, starve_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [XLEN-1:0]       mem_addr_nxt, mem_wdata_nxt;
  logic                  if_valid_nxt, d_valid_nxt;
  logic [XLEN-1:0]       if_rdata_nxt, d_rdata_nxt;
  logic                  starved;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;
  assign starved  = (starve_cnt == STARVE_W'(STARVE_MAX));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_valid   <= if_valid_nxt;
      d_valid    <= d_valid_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

  // Arbitration, backend sequencing and completion
  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_valid_nxt  = 1'b0;
    d_valid_nxt   = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    case (state)
      IDLE: begin
        // Data wins ties (older instruction) until fetch has waited STARVE_MAX grants
        if (if_req && (!d_req || starved)) begin
          state_nxt     = BUSY_I;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          starve_nxt    = '0;
        end else if (d_req) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (!if_req)
            starve_nxt = '0;
          else if (!starved)
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          if_valid_nxt = 1'b1;
          if_rdata_nxt = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          d_valid_nxt = 1'b1;
          if (!mem_we)
            d_rdata_nxt = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating contention and occupancy counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_busy     <= '0;
    end else begin
      if (state == IDLE && if_req && d_req && perf_conflict != '1)
        perf_conflict <= perf_conflict + CNT_W'(1);
      if (state != IDLE && perf_busy != '1)
        perf_busy <= perf_busy + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected grants and read data are queued by the
// stimulus and popped by a monitor whenever the DUT starts a backend access or pulses valid.
module tb_unified_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic        clk, reset;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflict, perf_busy;
`endif

  unified_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_busy(perf_busy)
`endif
  );

  int checks = 0;
  int errors = 0;

  grant_t      exp_grant[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];

  logic [31:0] mem_model [logic [31:0]];
  int          ack_dly = 0;
  int          bk_mode = 0;   // 0 modelled backend, 1 ack tied high, 2 driven by stimulus
  int          wcnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a;
  endfunction

  // Backend model: acks ack_dly cycles after mem_req appears
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bk_mode == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = lookup(mem_addr);
      end else if (bk_mode == 0) begin
        if (mem_req && !mem_ack) begin
          if (wcnt >= ack_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = lookup(mem_addr);
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          mem_ack = 1'b0;
          wcnt    = 0;
        end
      end
    end
  end

  // Monitor: grants on rising mem_req, read data on valid pulses
  initial begin
    logic   prev_req;
    grant_t g;
    logic [31:0] r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        checks++;
        if (exp_grant.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
        end else begin
          g = exp_grant.pop_front();
          if ({mem_we, mem_addr, mem_wdata} !== g) begin
            errors++;
            $display("FAIL grant: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, g.we, g.addr, g.wdata);
          end
        end
      end
      prev_req = mem_req;
      if (if_valid === 1'b1) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_valid_unexpected: got if_rdata %h", if_rdata);
        end else begin
          r = exp_if.pop_front();
          chk("if_rdata", if_rdata, r);
        end
      end
      if (d_valid === 1'b1) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_valid_unexpected: got d_rdata %h", d_rdata);
        end else begin
          r = exp_d.pop_front();
          chk("d_rdata", d_rdata, r);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int exp_lat);
    bit done = 1'b0;
    exp_if.push_back(rdata);
    if_addr = addr;
    if_req  = 1'b1;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(posedge clk); #1;
      if (if_valid) begin
        done = 1'b1;
        chk("if_stall_at_valid", 32'(if_stall), 32'd0);
        if (exp_lat > 0) chk("if_latency", n, exp_lat);
        if_req = 1'b0;
      end else begin
        chk("if_stall_wait", 32'(if_stall), 32'd1);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL if_timeout: got no if_valid for addr %h", addr);
      if_req = 1'b0;
    end
  endtask

  task automatic data_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input bit keep, input int exp_lat);
    bit done = 1'b0;
    exp_d.push_back(rdata);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(posedge clk); #1;
      if (d_valid) begin
        done = 1'b1;
        chk("d_stall_at_valid", 32'(d_stall), 32'd0);
        if (exp_lat > 0) chk("d_latency", n, exp_lat);
        if (!keep) d_req = 1'b0;
      end else begin
        chk("d_stall_wait", 32'(d_stall), 32'd1);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL d_timeout: got no d_valid for addr %h", addr);
      d_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    bk_mode = 1;
    mem_model[32'h4]   = 32'h1234_5678;
    mem_model[32'h40]  = 32'h8C22_0004;
    mem_model[32'h44]  = 32'h2442_0001;
    mem_model[32'h48]  = 32'h00A0_0093;
    mem_model[32'h4C]  = 32'h0000_0013;
    mem_model[32'h100] = 32'hCAFE_0100;
    mem_model[32'h104] = 32'h0000_0011;

    // Reset with fetch pending and ack tied high
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_d_valid", 32'(d_valid), 32'd0);
    end
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    exp_grant.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
    exp_if.push_back(32'h1234_5678);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    chk("first_if_valid", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    bk_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Single fetch with a 2-cycle backend delay
    ack_dly = 2;
    exp_grant.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    fetch(32'h40, 32'h8C22_0004, 4);
    ack_dly = 0;
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous fetch and load: data first, fetch in the following IDLE cycle
    exp_grant.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_grant.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    fork
      fetch(32'h44, 32'h2442_0001, 4);
      data_access(1'b0, 32'h100, 32'h0, 32'hCAFE_0100, 1'b0, 2);
    join
    repeat (2) @(posedge clk);
    #1;

    // Load 0x11, then store: d_rdata must hold 0x11
    exp_grant.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_grant.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF});
    data_access(1'b0, 32'h104, 32'h0, 32'h11, 1'b0, 2);
    data_access(1'b1, 32'h200, 32'hDEAD_BEEF, 32'h11, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;

    // Starvation: six back-to-back stores against one fetch -> D,D,D,D,I,D,D
    for (int k = 0; k < 4; k++)
      exp_grant.push_back('{we: 1'b1, addr: 32'h400 + 32'(4*k), wdata: 32'h1000_0000 + 32'(k)});
    exp_grant.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
    for (int k = 4; k < 6; k++)
      exp_grant.push_back('{we: 1'b1, addr: 32'h400 + 32'(4*k), wdata: 32'h1000_0000 + 32'(k)});
    fork
      fetch(32'h48, 32'h00A0_0093, 10);
      begin
        data_access(1'b1, 32'h400, 32'h1000_0000, 32'h11, 1'b1, 2);
        data_access(1'b1, 32'h404, 32'h1000_0001, 32'h11, 1'b1, 2);
        data_access(1'b1, 32'h408, 32'h1000_0002, 32'h11, 1'b1, 2);
        data_access(1'b1, 32'h40C, 32'h1000_0003, 32'h11, 1'b1, 2);
        data_access(1'b1, 32'h410, 32'h1000_0004, 32'h11, 1'b1, 4);
        data_access(1'b1, 32'h414, 32'h1000_0005, 32'h11, 1'b0, 2);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Stored data reaches the backend
    exp_grant.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_grant.push_back('{we: 1'b0, addr: 32'h404, wdata: 32'h0});
    data_access(1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    data_access(1'b0, 32'h404, 32'h0, 32'h1000_0001, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;

    // Reset during BUSY_D, then a late ack
    ack_dly = 5;
    exp_grant.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1; d_req = 1'b0; bk_mode = 2;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_d_valid", 32'(d_valid), 32'd0);
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end
    bk_mode = 0; ack_dly = 0;
    @(posedge clk); #1;
    exp_grant.push_back('{we: 1'b0, addr: 32'h4C, wdata: 32'h0});
    fetch(32'h4C, 32'h0000_0013, 2);

    repeat (5) @(posedge clk);
    #1;
    chk("grants_left", 32'(exp_grant.size()), 32'd0);
    chk("if_left", 32'(exp_if.size()), 32'd0);
    chk("d_left", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
